// File: rtl/breakout_pkg.sv
// Shared Breakout definitions: game states, brick count, miss threshold and the no-brick code.
// The ball-motion and renderer blocks use the same constants.
package breakout_pkg;

  localparam int         NUM_BRICKS = 12;
  localparam logic [9:0] MISS_Y     = 10'd4;
  localparam logic [9:0] NO_BRICK   = 10'd15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_WIN   = 3'd3,
    ST_LOSE  = 3'd4
  } state_t;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/brick_manager_if.sv
// Game-state bus between the ball-motion block, the brick manager and the display side.
// master drives frame/ball/hit inputs; slave is the brick manager.
interface brick_manager_if #(
  parameter int NUM_BRICKS = 12
);
  logic                  tick;
  logic                  start;
  logic                  hit_valid;
  logic [9:0]            hit_brick;
  logic [9:0]            ball_y;
  logic [NUM_BRICKS-1:0] brick_status;
  logic [7:0]            score;
  logic [1:0]            lives;
  logic                  ball_en;
  logic                  hit_ack;
  logic                  game_over;
  logic                  win;

  modport master (
    output tick, start, hit_valid, hit_brick, ball_y,
    input  brick_status, score, lives, ball_en, hit_ack, game_over, win
  );

  modport slave (
    input  tick, start, hit_valid, hit_brick, ball_y,
    output brick_status, score, lives, ball_en, hit_ack, game_over, win
  );
endinterface

// File: rtl/brick_manager_serve_timer.sv
// Serve hold-off counter: loads a tick count, decrements on each enabled tick.
// done is combinational: high on the enabled tick that sees the count at 1.
module brick_manager_serve_timer (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       tick,
  output logic       done
);
  logic [7:0] count;

  assign done = tick && (count == 8'd1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && count != 8'd0) begin
      count <= count - 8'd1;
    end
  end
endmodule

// File: rtl/brick_manager.sv
// Breakout game-state owner: brick wall, score, lives, serve hold-off and win/lose detection.
// Hits clear their brick one clock after hit_valid; a miss in the same cycle wins over the hit.
module brick_manager
  import breakout_pkg::*;
#(
  parameter int         NUM_BRICKS       = breakout_pkg::NUM_BRICKS,
  parameter logic [9:0] MISS_Y           = breakout_pkg::MISS_Y,
  parameter logic [1:0] START_LIVES      = 2'd3,
  parameter logic [7:0] SERVE_TICKS      = 8'd60,
  parameter logic [7:0] POINTS_PER_BRICK = 8'd1
) (
  input  logic          clk,
  input  logic          resetn,
  brick_manager_if.slave bus
);
  localparam logic [7:0] SERVE_LOAD = (SERVE_TICKS == 8'd0) ? 8'd1 : SERVE_TICKS;

  state_t                state;
  logic [NUM_BRICKS-1:0] bricks;
  logic [7:0]            score;
  logic [1:0]            lives;
  logic                  ball_en;
  logic                  hit_ack;
  logic                  miss_armed;

  logic [NUM_BRICKS-1:0] hit_mask;
  logic                  hit_ok;
  logic                  miss;
  logic                  restart;
  logic                  timer_load;
  logic                  serve_done;

  always_comb begin
    hit_mask = '0;
    for (int i = 0; i < NUM_BRICKS; i++) begin
      hit_mask[i] = (bus.hit_brick == 10'(i));
    end
  end

  // Out-of-range indices give an all-zero mask, so they can never be accepted.
  assign miss    = (state == ST_PLAY) && (bus.ball_y <= MISS_Y) && miss_armed;
  assign hit_ok  = (state == ST_PLAY) && bus.hit_valid && (bus.hit_brick != NO_BRICK)
                   && |(hit_mask & bricks) && !miss;
  assign restart = bus.start && (state == ST_IDLE || state == ST_WIN || state == ST_LOSE);
  assign timer_load = restart || (miss && lives != 2'd1);

  brick_manager_serve_timer u_serve_timer (
    .clk      (clk),
    .resetn   (resetn),
    .load     (timer_load),
    .load_val (SERVE_LOAD),
    .tick     (bus.tick && state == ST_SERVE),
    .done     (serve_done)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      bricks     <= '1;
      score      <= 8'd0;
      lives      <= START_LIVES;
      ball_en    <= 1'b0;
      hit_ack    <= 1'b0;
      miss_armed <= 1'b1;
    end else begin
      hit_ack <= 1'b0;
      if (bus.ball_y > MISS_Y) begin
        miss_armed <= 1'b1;
      end else if (miss) begin
        miss_armed <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          ball_en <= 1'b0;
          if (bus.start) begin
            state <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (serve_done) begin
            state   <= ST_PLAY;
            ball_en <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (miss) begin
            lives   <= lives - 2'd1;
            ball_en <= 1'b0;
            state   <= (lives == 2'd1) ? ST_LOSE : ST_SERVE;
          end else if (hit_ok) begin
            bricks  <= bricks & ~hit_mask;
            score   <= sat_add8(score, POINTS_PER_BRICK);
            hit_ack <= 1'b1;
            if ((bricks & ~hit_mask) == '0) begin
              state   <= ST_WIN;
              ball_en <= 1'b0;
            end
          end
        end
        ST_WIN, ST_LOSE: begin
          ball_en <= 1'b0;
          if (bus.start) begin
            bricks <= '1;
            score  <= 8'd0;
            lives  <= START_LIVES;
            state  <= ST_SERVE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          ball_en <= 1'b0;
        end
      endcase
    end
  end

  assign bus.brick_status = bricks;
  assign bus.score        = score;
  assign bus.lives        = lives;
  assign bus.ball_en      = ball_en;
  assign bus.hit_ack      = hit_ack;
  assign bus.win          = (state == ST_WIN);
  assign bus.game_over    = (state == ST_LOSE);
endmodule

// File: tb/tb_brick_manager.sv
// Randomised and directed checks of brick_manager against a game-rule reference model.
module tb_brick_manager;
  localparam int NB    = 12;
  localparam int SERVE = 3;
  localparam int G_IDLE = 0, G_SERVE = 1, G_PLAY = 2, G_WIN = 3, G_LOSE = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  brick_manager_if #(.NUM_BRICKS(NB)) bus ();

  brick_manager #(
    .NUM_BRICKS(NB), .MISS_Y(10'd4), .START_LIVES(2'd3),
    .SERVE_TICKS(8'(SERVE)), .POINTS_PER_BRICK(8'd1)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int       g_phase;
  bit [NB-1:0] g_wall;
  int       g_score, g_lives, g_wait;
  bit       g_armed, g_ack;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    g_phase = G_IDLE; g_wall = '1; g_score = 0; g_lives = 3;
    g_wait = 0; g_armed = 1'b1; g_ack = 1'b0;
  endfunction

  function automatic void model_step(bit t, bit s, bit hv, int hb, int by);
    bit was_play;
    was_play = (g_phase == G_PLAY);
    g_ack = 1'b0;
    if (g_phase == G_IDLE) begin
      if (s) begin g_phase = G_SERVE; g_wait = SERVE; end
    end else if (g_phase == G_SERVE) begin
      if (t) begin
        g_wait = g_wait - 1;
        if (g_wait == 0) g_phase = G_PLAY;
      end
    end else if (g_phase == G_PLAY) begin
      if (by <= 4 && g_armed) begin
        g_lives = g_lives - 1;
        if (g_lives == 0) g_phase = G_LOSE;
        else begin g_phase = G_SERVE; g_wait = SERVE; end
      end else if (hv && hb < NB && g_wall[hb]) begin
        g_wall[hb] = 1'b0;
        g_score = (g_score + 1 > 255) ? 255 : g_score + 1;
        g_ack = 1'b1;
        if (g_wall == 0) g_phase = G_WIN;
      end
    end else if (s) begin
      g_wall = '1; g_score = 0; g_lives = 3;
      g_phase = G_SERVE; g_wait = SERVE;
    end
    if (by > 4) g_armed = 1'b1;
    else if (was_play) g_armed = 1'b0;
  endfunction

  task automatic compare_all();
    chk("brick_status", 32'(bus.brick_status), 32'(g_wall));
    chk("score", 32'(bus.score), 32'(g_score));
    chk("lives", 32'(bus.lives), 32'(g_lives));
    chk("ball_en", 32'(bus.ball_en), 32'(g_phase == G_PLAY));
    chk("hit_ack", 32'(bus.hit_ack), 32'(g_ack));
    chk("win", 32'(bus.win), 32'(g_phase == G_WIN));
    chk("game_over", 32'(bus.game_over), 32'(g_phase == G_LOSE));
  endtask

  task automatic cyc(input bit t, input bit s, input bit hv, input int hb, input int by);
    bus.tick = t; bus.start = s; bus.hit_valid = hv;
    bus.hit_brick = 10'(hb); bus.ball_y = 10'(by);
    model_step(t, s, hv, hb, by);
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic do_reset();
    #2 resetn = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  initial begin
    bus.tick = 1'b0; bus.start = 1'b0; bus.hit_valid = 1'b0;
    bus.hit_brick = 10'd15; bus.ball_y = 10'd100;
    model_reset();
    #12;
    compare_all();
    resetn = 1'b1;
    #10;

    // Serve: ball_en rises on the edge after the third tick.
    cyc(0, 1, 0, 15, 100);
    cyc(1, 0, 0, 15, 100);
    cyc(0, 0, 0, 15, 100);
    cyc(1, 0, 0, 15, 100);
    chk("serve_hold", 32'(bus.ball_en), 32'd0);
    cyc(1, 0, 0, 15, 100);
    chk("serve_en", 32'(bus.ball_en), 32'd1);
    chk("serve_wall", 32'(bus.brick_status), 32'hFFF);

    cyc(0, 0, 1, 5, 100);
    chk("hit5_wall", 32'(bus.brick_status), 32'hFDF);
    chk("hit5_ack", 32'(bus.hit_ack), 32'd1);
    cyc(0, 0, 1, 5, 100);
    chk("rehit5_ack", 32'(bus.hit_ack), 32'd0);
    chk("rehit5_score", 32'(bus.score), 32'd1);
    cyc(0, 1, 1, 15, 100);
    cyc(0, 0, 1, 12, 100);
    chk("oob_wall", 32'(bus.brick_status), 32'hFDF);

    for (int i = 0; i < NB; i++) cyc(0, 0, 1, i, 100);
    chk("win", 32'(bus.win), 32'd1);
    chk("win_score", 32'(bus.score), 32'd12);
    cyc(0, 1, 0, 15, 100);
    chk("restart_wall", 32'(bus.brick_status), 32'hFFF);
    chk("restart_score", 32'(bus.score), 32'd0);
    for (int i = 0; i < SERVE; i++) cyc(1, 0, 0, 15, 100);

    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 15, 2);
    chk("miss_lives", 32'(bus.lives), 32'd2);
    chk("miss_serve", 32'(bus.ball_en), 32'd0);
    for (int i = 0; i < SERVE; i++) cyc(1, 0, 0, 15, 100);
    cyc(0, 0, 1, 0, 3);
    chk("prio_lives", 32'(bus.lives), 32'd1);
    chk("prio_bit0", 32'(bus.brick_status[0]), 32'd1);
    chk("prio_ack", 32'(bus.hit_ack), 32'd0);
    for (int i = 0; i < SERVE; i++) cyc(1, 0, 0, 15, 100);
    cyc(0, 0, 0, 15, 2);
    chk("lose", 32'(bus.game_over), 32'd1);
    cyc(0, 1, 0, 15, 100);
    cyc(1, 0, 0, 15, 100);
    do_reset();
    chk("rst_en", 32'(bus.ball_en), 32'd0);
    chk("rst_lives", 32'(bus.lives), 32'd3);

    for (int n = 0; n < 3000; n++) begin
      int by;
      by = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 6) : $urandom_range(5, 479);
      if ($urandom_range(0, 599) == 0) do_reset();
      else cyc($urandom_range(0, 2) == 0, $urandom_range(0, 30) == 0,
               $urandom_range(0, 1) == 1, $urandom_range(0, 15), by);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/brick_manager.md
Name: brick_manager

Overview:
- Owns the brick wall and the game state for Breakout. It is the writer of the brick_status vector that the ball-motion logic reads.
- Consumes the ball's brick-hit reports and ball Y position. Clears hit bricks, keeps score and lives, detects win/lose, and gates ball motion through ball_en.
- Sits between the ball-motion block and the VGA renderer / score display.

Parameters:
- NUM_BRICKS, 12, number of bricks; width of brick_status.
- MISS_Y, 10'd4, ball_y at or below this value counts as a missed ball (below the paddle row).
- START_LIVES, 2'd3, lives loaded at game start.
- SERVE_TICKS, 8'd60, frame ticks the ball is held before each serve.
- POINTS_PER_BRICK, 8'd1, score increment per cleared brick.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- tick  in  1  one-cycle frame-rate enable, the same strobe that drives ball motion.
- start  in  1  level; begins or restarts a game.
- hit_valid  in  1  ball logic reports a brick contact this cycle.
- hit_brick  in  10  brick index of the contact; 10'd15 means no brick.
- ball_y  in  10  current ball Y.
- brick_status  out  NUM_BRICKS  1 = brick present.
- score  out  8  cleared-brick score, saturating.
- lives  out  2  remaining lives.
- ball_en  out  1  enables ball motion; drives the ball block's en.
- hit_ack  out  1  one-cycle pulse when a hit is accepted.
- game_over  out  1  high in LOSE.
- win  out  1  high in WIN.

Behaviour:
- Reset values (async, resetn low):
  - state = IDLE, brick_status = all ones, score = 0, lives = START_LIVES.
  - ball_en = 0, hit_ack = 0, game_over = 0, win = 0.
  - serve counter = 0, miss_armed = 1.
- States: IDLE, SERVE, PLAY, WIN, LOSE.
- IDLE:
  - ball_en = 0.
  - start = 1 -> SERVE next cycle. The serve counter is loaded with SERVE_TICKS.
- SERVE:
  - ball_en = 0.
  - Counter decrements on each tick.
  - On the tick where the counter is 1 -> PLAY next cycle.
  - SERVE_TICKS = 0 is treated as 1.
- PLAY:
  - ball_en = 1.
  - Hit acceptance: hit_valid = 1, hit_brick < NUM_BRICKS and brick_status[hit_brick] = 1.
    - Next edge: that bit clears, score += POINTS_PER_BRICK (saturating at 255), and hit_ack is high for exactly that one cycle.
    - Latency from hit_valid to the cleared bit is 1 clock.
  - Hits are ignored (no ack, no score change) when the brick is already cleared, when hit_brick = 15, or when hit_brick >= NUM_BRICKS.
  - Miss detection:
    - Fires when ball_y <= MISS_Y and miss_armed = 1. miss_armed then clears.
    - miss_armed sets again when ball_y > MISS_Y.
    - A miss decrements lives. If lives was 1 -> LOSE. Otherwise -> SERVE, with the counter reloaded.
  - Hit and miss in the same cycle: the miss has priority and the hit is dropped (no clear, no ack).
  - Accepting the hit that clears the last remaining brick -> WIN on the same edge as the clear.
- WIN and LOSE:
  - ball_en = 0.
  - win or game_over is held high for as long as the block stays in the state.
  - start = 1 -> reinitialise: all bricks = 1, score = 0, lives = START_LIVES, then SERVE.
- start while in SERVE or PLAY is ignored.
- Outputs are registered. win and game_over are decoded from the state register.
- Reset in the middle of a hit or a serve abandons it: no pending ack, and the bricks restore to all ones.

Decomposition:
- Shared package breakout_pkg holds:
  - state encodings, 3-bit: IDLE = 0, SERVE = 1, PLAY = 2, WIN = 3, LOSE = 4.
  - NO_BRICK = 10'd15, NUM_BRICKS and MISS_Y, all shared with the ball and renderer blocks.
- One natural sub-module: serve_timer (load, tick-decrement, done flag).

Test Plan:
- Reset, then start pulse with SERVE_TICKS = 3 -> ball_en rises exactly 1 clock after the 3rd tick. brick_status = 12'hFFF, lives = 3.
- PLAY, hit_valid with hit_brick = 5 -> next cycle brick_status = 12'hFDF, score = 1, hit_ack high for 1 cycle. Repeating hit_brick = 5 -> no ack, score stays 1.
- hit_valid with hit_brick = 15, then with hit_brick = 12 -> brick_status, score and hit_ack all unchanged.
- Clear all 12 bricks in sequence -> win = 1, ball_en = 0 on the edge that clears the final bit. start -> status back to 12'hFFF, score = 0.
- ball_y held at 2 for 10 cycles -> exactly one decrement, lives 3 -> 2, state SERVE. Three armed misses total -> game_over = 1.
- ball_y = 3 with hit_valid and hit_brick = 0 in the same cycle -> lives decrement, bit 0 still 1, no hit_ack. resetn low during SERVE -> IDLE, outputs at reset values.
